// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   arbState_e  - arbiter FSM state (IDLE, BUSY_I, BUSY_D, RESP)
//   ERR_WORD    - word returned to a load/fetch that was aborted by the watchdog
//   STREAK_W    - width of the data-grant streak counter
//   TIMER_W     - width of the watchdog counter
//   isBusy()    - true in either memory-access state
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arbState_e;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TIMER_W  = 8;

    function automatic logic isBusy(input arbState_e s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Watchdog for an outstanding memory access. Counts enabled cycles since the
// last clear and flags expiry once LIMIT cycles have elapsed.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear (held while no access is in flight)
//   enable    - count this cycle (busy and no acknowledge)
//   expired   - count has reached LIMIT
// -----------------------------------------------------------------------------
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT_V = TIMER_W'(LIMIT);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a fetch port and a data port onto a single-ported memory.
// Data requests win ties until DSTREAK_MAX consecutive data grants have been
// made while a fetch was waiting; the fetch is then granted. Each access runs
// IDLE -> BUSY_x -> RESP -> IDLE, so back-to-back accesses take >= 3 cycles.
// A watchdog aborts an access after ACK_TIMEOUT unacknowledged busy cycles,
// returns ERR_WORD to loads/fetches and sets the sticky bus_err flag.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request (held until if_ready)
//   if_rdata, if_ready            fetched word, one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata  data request (held until d_ready)
//   d_rdata, d_ready              load data, one-cycle completion pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata                     memory command, valid for every busy cycle
//   mem_rdata, mem_ack            memory response
//   bus_err                       sticky timeout indication
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DSTREAK_MAX = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        bus_err
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DSTREAK_MAX);

    arbState_e           state;
    logic [STREAK_W-1:0] dStreak;
    logic                inBusy;
    logic                timerExpired;

    assign inBusy = isBusy(state);

    // Counter is held clear outside BUSY, so every access starts from zero.
    mem_arb_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!inBusy),
        .enable  (inBusy && !mem_ack),
        .expired (timerExpired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dStreak   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            // Ready strobes last exactly the RESP cycle.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            case (state)
                IDLE: begin
                    if (d_req && (!if_req || (dStreak < STREAK_LIMIT))) begin
                        state     <= BUSY_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // Streak only counts grants that made a fetch wait.
                        dStreak   <= if_req ? (dStreak + 1'b1) : '0;
                    end else if (if_req) begin
                        state     <= BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        dStreak   <= '0;
                    end else begin
                        dStreak   <= '0;
                    end
                end

                BUSY_I: begin
                    // An ack arriving on the expiry cycle still counts as success.
                    if (mem_ack || timerExpired) begin
                        state    <= RESP;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_ack ? mem_rdata : ERR_WORD;
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                    end
                end

                BUSY_D: begin
                    if (mem_ack || timerExpired) begin
                        state   <= RESP;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_ack ? mem_rdata : ERR_WORD;
                        end
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (DSTREAK_MAX=4, ACK_TIMEOUT=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, so each tick() represents one clock cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int          DMAX = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

    logic        clk, rst;
    logic        if_req, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ack, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;

    // memory environment
    logic        memAuto   = 1'b0;
    logic        memSilent = 1'b0;
    logic        useFixed  = 1'b0;
    logic [31:0] fixedData = '0;
    int          memWait    = 0;
    int          memLatency = 0;

    mem_arbiter #(
        .DSTREAK_MAX (DMAX),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // One clock cycle; the memory model answers mem_en after memLatency cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (memAuto) begin
            if (mem_en) begin
                if (!memSilent && memWait == memLatency) begin
                    mem_ack   = 1'b1;
                    mem_rdata = useFixed ? fixedData : memWord(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                memWait++;
            end else begin
                mem_ack = 1'b0;
                memWait = 0;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        memAuto = 1'b0; memSilent = 1'b0; useFixed = 1'b0; memWait = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Issues one request at the current cycle (cycle 0) and runs until ready.
    // lat < 0 means the memory never acknowledges.
    task automatic runAccess(input logic isData, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat,
                             output int readyCyc, output int enCyc,
                             output logic [31:0] firstAddr, output logic [31:0] firstWdata,
                             output logic firstWe, output logic stable,
                             output logic otherReady);
        readyCyc = -1; enCyc = 0; otherReady = 1'b0; stable = 1'b1;
        firstAddr = '0; firstWdata = '0; firstWe = 1'b0;
        memAuto = 1'b1; memSilent = (lat < 0); memLatency = (lat < 0) ? 0 : lat; memWait = 0;
        if (isData) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k <= 40 && readyCyc < 0; k++) begin
            tick();
            if (mem_en) begin
                if (enCyc == 0) begin
                    firstAddr = mem_addr; firstWdata = mem_wdata; firstWe = mem_we;
                end else if (mem_addr !== firstAddr || mem_wdata !== firstWdata || mem_we !== firstWe) begin
                    stable = 1'b0;
                end
                enCyc++;
            end
            if (isData ? if_ready : d_ready) otherReady = 1'b1;
            if (isData ? d_ready : if_ready) begin
                readyCyc = k;
                d_req = 1'b0;
                if_req = 1'b0;
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hFFFF_FFFF;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        memAuto = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        totalCnt++; if ({mem_en, mem_we, if_ready, d_ready, bus_err} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {mem_en, mem_we, if_ready, d_ready, bus_err}); else passCnt++;
        totalCnt++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem got=%h/%h want=0/0", mem_addr, mem_wdata); else passCnt++;
        totalCnt++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata, d_rdata); else passCnt++;
        doReset();
        tick();
        totalCnt++; if ({mem_en, if_ready, d_ready, bus_err} !== 4'b0) $display("FAIL reset_release got=%b want=0000", {mem_en, if_ready, d_ready, bus_err}); else passCnt++;
    endtask

    task automatic test_fetch();
        int rc, ec; logic [31:0] fa, fw; logic fwe, st, oth;
        doReset();
        useFixed = 1'b1; fixedData = 32'h8C22_0004;
        runAccess(1'b0, 1'b0, 32'h40, 32'h0, 2, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (rc != 4) $display("FAIL fetch_ready_cycle got=%0d want=4", rc); else passCnt++;
        totalCnt++; if (if_rdata !== 32'h8C22_0004) $display("FAIL fetch_rdata got=%h want=8c220004", if_rdata); else passCnt++;
        totalCnt++; if (fwe !== 1'b0 || fa !== 32'h40 || !st) $display("FAIL fetch_mem got we=%b addr=%h stable=%b want we=0 addr=40 stable=1", fwe, fa, st); else passCnt++;
        totalCnt++; if (ec != 3 || oth) $display("FAIL fetch_en_cycles got=%0d other=%b want=3 other=0", ec, oth); else passCnt++;
    endtask

    task automatic test_idle_ack();
        int rc, ec; logic [31:0] fa, fw; logic fwe, st, oth;
        logic sawReady;
        doReset();
        runAccess(1'b0, 1'b0, 32'h44, 32'h0, 1, rc, ec, fa, fw, fwe, st, oth);
        memAuto = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 1'b0;
        sawReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (if_ready || d_ready || mem_en) sawReady = 1'b1;
        end
        totalCnt++; if (sawReady) $display("FAIL idle_ack_ready got=1 want=0"); else passCnt++;
        totalCnt++; if (if_rdata !== memWord(32'h44)) $display("FAIL idle_ack_if_rdata got=%h want=%h", if_rdata, memWord(32'h44)); else passCnt++;
        totalCnt++; if (d_rdata !== 32'h0) $display("FAIL idle_ack_d_rdata got=%h want=0", d_rdata); else passCnt++;
    endtask

    task automatic test_store();
        int rc, ec; logic [31:0] fa, fw; logic fwe, st, oth;
        doReset();
        useFixed = 1'b1; fixedData = 32'hCAFE_F00D;
        runAccess(1'b1, 1'b0, 32'h104, 32'h0, 1, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (d_rdata !== 32'hCAFE_F00D || rc != 3) $display("FAIL load_before_store got=%h cyc=%0d want=cafef00d cyc=3", d_rdata, rc); else passCnt++;
        fixedData = 32'h0BAD_0BAD;
        runAccess(1'b1, 1'b1, 32'h100, 32'h1234_5678, 2, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (fwe !== 1'b1 || fa !== 32'h100 || fw !== 32'h1234_5678 || !st) $display("FAIL store_mem got we=%b addr=%h wdata=%h stable=%b want 1/100/12345678/1", fwe, fa, fw, st); else passCnt++;
        totalCnt++; if (rc != 4 || oth) $display("FAIL store_ready got=%0d other=%b want=4 other=0", rc, oth); else passCnt++;
        totalCnt++; if (d_rdata !== 32'hCAFE_F00D) $display("FAIL store_rdata_kept got=%h want=cafef00d", d_rdata); else passCnt++;
    endtask

    task automatic test_fairness();
        int   gCyc[10];
        logic gD[10];
        int   g;
        logic prevEn, expD;
        doReset();
        memAuto = 1'b1; memSilent = 1'b0; memLatency = 0; memWait = 0;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        g = 0; prevEn = 1'b0;
        for (int k = 1; k <= 60 && g < 10; k++) begin
            tick();
            if (mem_en && !prevEn) begin
                gCyc[g] = k;
                gD[g] = (mem_addr == 32'h300);
                g++;
            end
            prevEn = mem_en;
        end
        totalCnt++; if (g != 10) $display("FAIL fair_grant_count got=%0d want=10", g); else passCnt++;
        for (int i = 0; i < g; i++) begin
            expD = ((i % (DMAX + 1)) != DMAX);
            totalCnt++; if (gD[i] !== expD) $display("FAIL fair_order[%0d] got D=%b want D=%b", i, gD[i], expD); else passCnt++;
            if (i > 0) begin
                totalCnt++; if (gCyc[i] - gCyc[i-1] != 3) $display("FAIL fair_period[%0d] got=%0d want=3", i, gCyc[i] - gCyc[i-1]); else passCnt++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int rc, ec; logic [31:0] fa, fw; logic fwe, st, oth;
        doReset();
        // ack on the very cycle the watchdog expires: normal completion
        runAccess(1'b1, 1'b0, 32'h88, 32'h0, TMO, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (rc != TMO + 2 || d_rdata !== memWord(32'h88)) $display("FAIL ack_at_limit got cyc=%0d data=%h want cyc=%0d data=%h", rc, d_rdata, TMO + 2, memWord(32'h88)); else passCnt++;
        totalCnt++; if (bus_err !== 1'b0) $display("FAIL ack_at_limit_err got=%b want=0", bus_err); else passCnt++;
        // no ack at all
        runAccess(1'b1, 1'b0, 32'h8C, 32'h0, -1, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (rc != TMO + 2 || ec != TMO + 1) $display("FAIL timeout_ready got cyc=%0d en=%0d want cyc=%0d en=%0d", rc, ec, TMO + 2, TMO + 1); else passCnt++;
        totalCnt++; if (d_rdata !== ERRW) $display("FAIL timeout_rdata got=%h want=%h", d_rdata, ERRW); else passCnt++;
        totalCnt++; if (bus_err !== 1'b1) $display("FAIL timeout_err got=%b want=1", bus_err); else passCnt++;
        runAccess(1'b0, 1'b0, 32'h90, 32'h0, -1, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (if_rdata !== ERRW || rc != TMO + 2) $display("FAIL timeout_fetch got=%h cyc=%0d want=%h cyc=%0d", if_rdata, rc, ERRW, TMO + 2); else passCnt++;
        runAccess(1'b0, 1'b0, 32'h94, 32'h0, 0, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (bus_err !== 1'b1 || if_rdata !== memWord(32'h94)) $display("FAIL err_sticky got err=%b data=%h want err=1 data=%h", bus_err, if_rdata, memWord(32'h94)); else passCnt++;
        doReset();
        totalCnt++; if (bus_err !== 1'b0) $display("FAIL err_cleared got=%b want=0", bus_err); else passCnt++;
    endtask

    task automatic test_reset_mid_busy();
        int rc, ec; logic [31:0] fa, fw; logic fwe, st, oth;
        logic bad;
        doReset();
        memAuto = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick();
        tick();
        totalCnt++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) $display("FAIL midbusy_pre got en=%b addr=%h want en=1 addr=40", mem_en, mem_addr); else passCnt++;
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        totalCnt++; if ({mem_en, mem_we, d_ready, if_ready, bus_err} !== 5'b0 || mem_addr !== 32'h0) $display("FAIL midbusy_async got=%b addr=%h want=00000 addr=0", {mem_en, mem_we, d_ready, if_ready, bus_err}, mem_addr); else passCnt++;
        tick();
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (d_ready || if_ready || mem_en || d_rdata !== 32'h0) bad = 1'b1;
        end
        totalCnt++; if (bad) $display("FAIL midbusy_late_ack got=activity want=quiet"); else passCnt++;
        runAccess(1'b0, 1'b0, 32'h60, 32'h0, 0, rc, ec, fa, fw, fwe, st, oth);
        totalCnt++; if (rc != 2) $display("FAIL midbusy_idle_after got=%0d want=2", rc); else passCnt++;
    endtask

    task automatic test_random();
        int   busyFrom, busyTo, readyAt, nextIdle, streak, lat, nI, nD;
        logic expPortD, expWe, pendLoad, expEn;
        logic [31:0] expAddr, expWdata, pendData, mIfR, mDR;
        logic iAct, iGr, dAct, dGr;
        doReset();
        memAuto = 1'b1; memSilent = 1'b0; useFixed = 1'b0; memLatency = 0; memWait = 0;
        busyFrom = -10; busyTo = -10; readyAt = -10; nextIdle = 1; streak = 0;
        expPortD = 1'b0; expWe = 1'b0; pendLoad = 1'b0;
        expAddr = '0; expWdata = '0; pendData = '0; mIfR = '0; mDR = '0;
        iAct = 1'b0; iGr = 1'b0; dAct = 1'b0; dGr = 1'b0; nI = 0; nD = 0;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (c == readyAt && pendLoad) begin
                if (expPortD) mDR = pendData; else mIfR = pendData;
            end
            expEn = (c >= busyFrom) && (c <= busyTo);
            totalCnt++; if (mem_en !== expEn) $display("FAIL rnd_mem_en c=%0d got=%b want=%b", c, mem_en, expEn); else passCnt++;
            if (expEn) begin
                totalCnt++; if (mem_addr !== expAddr || mem_we !== expWe) $display("FAIL rnd_mem_cmd c=%0d got=%h/%b want=%h/%b", c, mem_addr, mem_we, expAddr, expWe); else passCnt++;
                if (expWe) begin
                    totalCnt++; if (mem_wdata !== expWdata) $display("FAIL rnd_mem_wdata c=%0d got=%h want=%h", c, mem_wdata, expWdata); else passCnt++;
                end
            end
            totalCnt++; if (if_ready !== (c == readyAt && !expPortD) || d_ready !== (c == readyAt && expPortD)) $display("FAIL rnd_ready c=%0d got=%b%b want=%b%b", c, if_ready, d_ready, (c == readyAt && !expPortD), (c == readyAt && expPortD)); else passCnt++;
            totalCnt++; if (if_rdata !== mIfR || d_rdata !== mDR) $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, if_rdata, d_rdata, mIfR, mDR); else passCnt++;
            totalCnt++; if (bus_err !== 1'b0) $display("FAIL rnd_bus_err c=%0d got=%b want=0", c, bus_err); else passCnt++;

            // requesters: finish on ready, start new work at random, drop while granted
            if (c == readyAt) begin
                if (expPortD) begin dAct = 1'b0; dGr = 1'b0; end
                else begin iAct = 1'b0; iGr = 1'b0; end
            end
            if (!iAct && $urandom_range(0, 2) == 0) begin
                iAct = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dAct && $urandom_range(0, 2) == 0) begin
                dAct = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
            end
            if_req = iGr ? ($urandom_range(0, 7) != 0) : iAct;
            d_req  = dGr ? ($urandom_range(0, 7) != 0) : dAct;

            if (c == nextIdle) begin
                lat = $urandom_range(0, 3);
                if (d_req && (!if_req || streak < DMAX)) begin
                    streak = if_req ? streak + 1 : 0;
                    expPortD = 1'b1; expWe = d_we; expAddr = d_addr; expWdata = d_wdata;
                    pendLoad = !d_we; pendData = memWord(d_addr); dGr = 1'b1; nD++;
                end else if (if_req) begin
                    streak = 0;
                    expPortD = 1'b0; expWe = 1'b0; expAddr = if_addr; expWdata = '0;
                    pendLoad = 1'b1; pendData = memWord(if_addr); iGr = 1'b1; nI++;
                end else begin
                    streak = 0;
                    lat = -1;
                end
                if (lat >= 0) begin
                    memLatency = lat;
                    busyFrom = c + 1; busyTo = c + 1 + lat;
                    readyAt = c + 2 + lat; nextIdle = c + 3 + lat;
                end else begin
                    nextIdle = c + 1;
                end
            end
        end
        totalCnt++; if (nI == 0 || nD == 0) $display("FAIL rnd_both_ports got I=%0d D=%0d want both>0", nI, nD); else passCnt++;
        if_req = 1'b0; d_req = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_idle_ack();
        test_store();
        test_fairness();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DSTREAK_MAX, 4, consecutive data grants allowed while fetch waits (1..15).
REQ-002 Parameter: ACK_TIMEOUT, 255, cycles in BUSY without mem_ack before abort (1..255).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch port request; held with if_addr stable until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched word, registered.
REQ-008 if_ready  out  1  one-cycle completion pulse for fetch.
REQ-009 d_req  in  1  data port request; held with d_we/d_addr/d_wdata stable until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_rdata  out  32  load data, registered.
REQ-014 d_ready  out  1  one-cycle completion pulse for data.
REQ-015 mem_en  out  1  memory access active; high for every BUSY cycle.
REQ-016 mem_we  out  1  write strobe, valid with mem_en.
REQ-017 mem_addr  out  32  address, valid with mem_en.
REQ-018 mem_wdata  out  32  write data, valid with mem_en.
REQ-019 mem_rdata  in  32  read data, valid with mem_ack.
REQ-020 mem_ack  in  1  one-cycle completion from memory; any latency >= 0 cycles after mem_en rises.
REQ-021 bus_err  out  1  sticky: set on any timeout abort.

Function
REQ-022 FSM states IDLE, BUSY_I, BUSY_D, RESP; grant decided only in IDLE.
REQ-023 IDLE: d_req only -> BUSY_D; if_req only -> BUSY_I; none -> stay IDLE.
REQ-024 IDLE, both requesting: BUSY_D if d_streak < DSTREAK_MAX, else BUSY_I.
REQ-025 d_streak (4 bit): +1 on each D grant while if_req high, saturating at DSTREAK_MAX; cleared on every I grant and whenever if_req low in IDLE.
REQ-026 BUSY_x: mem_en=1, mem_addr/mem_we/mem_wdata driven from granted port's request registered at grant; mem_we=0 in BUSY_I.
REQ-027 BUSY_x with mem_ack: capture mem_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D load); store leaves d_rdata unchanged; -> RESP.
REQ-028 RESP: exactly one of if_ready/d_ready = 1 for the granted port, mem_en=0; -> IDLE next cycle unconditionally.
REQ-029 Latency: req seen in IDLE at cycle 0, mem_ack at cycle 1+L -> ready at cycle 2+L; minimum back-to-back period 3 cycles.
REQ-030 Watchdog counter clears on BUSY entry, increments each BUSY cycle without mem_ack; at ACK_TIMEOUT -> RESP, port rdata loaded with 32'hDEAD_BEEF (loads/fetches), bus_err set.
REQ-031 mem_ack in IDLE or RESP ignored; mem_ack coincident with timeout treated as normal ack, no error.
REQ-032 Request drop while BUSY ignored; access completes and ready still pulses.
REQ-033 mem_en, mem_we, if_ready, d_ready, bus_err registered (no combinational input-to-output path).

Reset
REQ-034 rst asynchronously forces IDLE, d_streak=0, watchdog=0, all outputs 0 (rdata registers 32'h0, bus_err 0).
REQ-035 Reset mid-BUSY abandons access without ready pulse; late mem_ack after release ignored.

Structure
REQ-036 Shared package mem_arb_pkg holds state enum and constant ERR_WORD = 32'hDEAD_BEEF.
REQ-037 One sub-module mem_arb_timer: watchdog counter with clear/enable inputs and expired output.
REQ-038 Target size 120-400 lines RTL.

Verification
REQ-039 Fetch only, if_addr=0x40, mem_ack 2 cycles after mem_en, mem_rdata=0x8C220004 -> if_ready at cycle 4, if_rdata=0x8C220004, mem_we=0.
REQ-040 Both held high continuously, DSTREAK_MAX=4, zero-latency ack -> grant order D,D,D,D,I,D,D,D,D,I; period 3 cycles each.
REQ-041 Store d_we=1, d_addr=0x100, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x100, mem_wdata=0x12345678 while mem_en; d_ready pulse; d_rdata unchanged.
REQ-042 Load, mem_ack never sent, ACK_TIMEOUT=8 -> d_ready 9 cycles after BUSY entry, d_rdata=0xDEADBEEF, bus_err=1 until rst.
REQ-043 rst asserted in BUSY_D cycle 2, mem_ack one cycle after release -> no d_ready, state IDLE, all outputs 0.
REQ-044 mem_ack pulsed while IDLE with no requests -> no ready, no rdata change.
